// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the 512x32 synchronous single-port RAM.
// One request at a time over valid/ready; all outputs come straight from flops.
module mem_access_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            ram_we      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        ram_addr    <= req_addr;
                        ram_data_in <= req_wdata;
                        req_ready   <= 1'b0;
                        if (req_write) begin
                            ram_we  <= 1'b1;
                            r_state <= WRITE;
                        end else begin
                            r_cnt   <= 3'(RD_LATENCY);
                            r_state <= READ;
                        end
                    end
                end
                WRITE: begin
                    ram_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    r_state    <= RESP;
                end
                READ: begin
                    // Address is held, so the RAM word is stable once the count expires.
                    if (r_cnt != 3'd0) begin
                        r_cnt <= 3'(r_cnt - 3'd1);
                    end else begin
                        resp_rdata <= ram_data_out;
                        resp_valid <= 1'b1;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (read latency 1 and 3) share one request stream,
// each with its own RAM model and a transaction-level reference model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqWrite = 1'b0;
    logic [8:0]  reqAddr = '0;
    logic [31:0] reqWdata = '0;

    logic        reqReady  [2];
    logic        respValid [2];
    logic        ramWe     [2];
    logic [31:0] respRdata [2];
    logic [31:0] ramDin    [2];
    logic [31:0] ramDout   [2];
    logic [8:0]  ramAddr   [2];
    logic        modelBusy [2];

    logic [8:0]  pool [16];
    int          checks = 0;
    int          passes = 0;
    bit          cmpEn = 1'b0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [31:0] mem    [512];
        logic [31:0] pipe   [LAT];
        logic [31:0] refMem [512];
        logic        busy;
        logic        curWrite;
        int          k;
        int          respK;
        logic [8:0]  curAddr;
        logic [8:0]  expAddr;
        logic [31:0] expWdata;
        logic [31:0] expRdata;

        mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .RD_LATENCY(LAT)) dut (
            .clk(clk),
            .rst_n(rst_n),
            .req_valid(reqValid),
            .req_ready(reqReady[g]),
            .req_write(reqWrite),
            .req_addr(reqAddr),
            .req_wdata(reqWdata),
            .resp_valid(respValid[g]),
            .resp_rdata(respRdata[g]),
            .ram_addr(ramAddr[g]),
            .ram_data_in(ramDin[g]),
            .ram_we(ramWe[g]),
            .ram_data_out(ramDout[g])
        );

        // Synchronous RAM whose read data appears LAT edges after the address is sampled.
        always @(posedge clk) begin
            if (ramWe[g]) mem[ramAddr[g]] <= ramDin[g];
            pipe[0] <= mem[ramAddr[g]];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign ramDout[g] = pipe[LAT-1];

        // Transaction model: k counts cycles since accept; response sits in cycle respK.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy     <= 1'b0;
                curWrite <= 1'b0;
                k        <= 0;
                respK    <= 0;
                curAddr  <= '0;
                expAddr  <= '0;
                expWdata <= '0;
                expRdata <= '0;
            end else if (busy) begin
                k <= k + 1;
                if (k + 1 > respK) busy <= 1'b0;
                if (!curWrite && (k + 1 == respK)) expRdata <= refMem[curAddr];
            end else if (reqValid) begin
                busy     <= 1'b1;
                k        <= 1;
                curWrite <= reqWrite;
                curAddr  <= reqAddr;
                expAddr  <= reqAddr;
                expWdata <= reqWdata;
                respK    <= reqWrite ? 2 : LAT + 2;
                if (reqWrite) refMem[reqAddr] <= reqWdata;
            end
        end
        assign modelBusy[g] = busy;

        always @(negedge clk) begin
            if (rst_n && cmpEn) begin
                checkOutput($sformatf("L%0d req_ready", LAT), 32'(reqReady[g]), 32'(!busy));
                checkOutput($sformatf("L%0d ram_we", LAT), 32'(ramWe[g]), 32'(busy && curWrite && k == 1));
                checkOutput($sformatf("L%0d resp_valid", LAT), 32'(respValid[g]), 32'(busy && k == respK));
                checkOutput($sformatf("L%0d resp_rdata", LAT), respRdata[g], expRdata);
                checkOutput($sformatf("L%0d ram_addr", LAT), 32'(ramAddr[g]), 32'(expAddr));
                checkOutput($sformatf("L%0d ram_data_in", LAT), ramDin[g], expWdata);
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        while ((modelBusy[0] || modelBusy[1]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("waitIdle timeout", 32'd1, 32'd0);
    endtask

    task automatic applyStimulus(input bit w, input logic [8:0] a, input logic [31:0] d);
        waitIdle();
        reqValid = 1'b1;
        reqWrite = w;
        reqAddr  = a;
        reqWdata = d;
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    // Issues one request and reports edges from accept to response plus the returned word.
    task automatic measureLatency(input bit w, input logic [8:0] a, input logic [31:0] d,
                                  output int lat0, output int lat1,
                                  output logic [31:0] rd0, output logic [31:0] rd1);
        lat0 = -1;
        lat1 = -1;
        rd0  = '0;
        rd1  = '0;
        applyStimulus(w, a, d);
        for (int n = 1; n <= 20; n++) begin
            if (respValid[0] && lat0 < 0) begin
                lat0 = n - 1;
                rd0  = respRdata[0];
            end
            if (respValid[1] && lat1 < 0) begin
                lat1 = n - 1;
                rd1  = respRdata[1];
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int l0, l1;
        logic [31:0] d0, d1;

        pool[0] = 9'h000;
        pool[1] = 9'h1FF;
        pool[2] = 9'h1A5;
        pool[3] = 9'h0F0;
        for (int i = 4; i < 16; i++) pool[i] = 9'($urandom_range(0, 511));

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput("reset req_ready", 32'(reqReady[g]), 32'd1);
            checkOutput("reset resp_valid", 32'(respValid[g]), 32'd0);
            checkOutput("reset resp_rdata", respRdata[g], 32'd0);
            checkOutput("reset ram_addr", 32'(ramAddr[g]), 32'd0);
            checkOutput("reset ram_we", 32'(ramWe[g]), 32'd0);
        end
        rst_n = 1'b1;
        cmpEn = 1'b1;

        for (int i = 0; i < 16; i++) applyStimulus(1'b1, pool[i], $urandom);

        measureLatency(1'b1, 9'h1A5, 32'hDEADBEEF, l0, l1, d0, d1);
        checkOutput("write latency L1", 32'(l0), 32'd1);
        checkOutput("write latency L3", 32'(l1), 32'd1);
        measureLatency(1'b0, 9'h1A5, 32'h0, l0, l1, d0, d1);
        checkOutput("read latency L1", 32'(l0), 32'd2);
        checkOutput("read data L1", d0, 32'hDEADBEEF);
        checkOutput("read latency L3", 32'(l1), 32'd4);

        measureLatency(1'b1, 9'h000, 32'h11111111, l0, l1, d0, d1);
        measureLatency(1'b1, 9'h1FF, 32'h22222222, l0, l1, d0, d1);
        measureLatency(1'b0, 9'h000, 32'h0, l0, l1, d0, d1);
        checkOutput("read 0x000", d0, 32'h11111111);
        checkOutput("ram_addr 0x000", 32'(ramAddr[0]), 32'h000);
        measureLatency(1'b0, 9'h1FF, 32'h0, l0, l1, d0, d1);
        checkOutput("read 0x1FF", d0, 32'h22222222);
        checkOutput("ram_addr 0x1FF", 32'(ramAddr[0]), 32'h1FF);

        measureLatency(1'b1, 9'h0F0, 32'hCAFEF00D, l0, l1, d0, d1);
        measureLatency(1'b0, 9'h0F0, 32'h0, l0, l1, d0, d1);
        checkOutput("L3 read latency 0x0F0", 32'(l1), 32'd4);
        checkOutput("L3 read data 0x0F0", d1, 32'hCAFEF00D);

        // Valid held high while busy: new address/data must not disturb the request in flight.
        waitIdle();
        reqValid = 1'b1;
        reqWrite = 1'b0;
        reqAddr  = 9'h1A5;
        @(negedge clk);
        reqWrite = 1'b1;
        reqAddr  = 9'h0AA;
        reqWdata = 32'h5A5A5A5A;
        @(negedge clk);
        checkOutput("busy ram_addr held", 32'(ramAddr[0]), 32'h1A5);
        checkOutput("busy ram_we held", 32'(ramWe[0]), 32'd0);
        for (int i = 0; i < 10; i++) begin
            reqWrite = i[0];
            reqAddr  = i[0] ? 9'h0AA : 9'h000;
            reqWdata = $urandom;
            @(negedge clk);
        end
        reqValid = 1'b0;
        waitIdle();

        applyStimulus(1'b0, 9'h1A5, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort resp_valid", 32'(respValid[0]), 32'd0);
        checkOutput("abort resp_rdata", respRdata[0], 32'd0);
        checkOutput("abort req_ready", 32'(reqReady[0]), 32'd1);
        checkOutput("abort ram_addr", 32'(ramAddr[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        measureLatency(1'b0, 9'h1A5, 32'h0, l0, l1, d0, d1);
        checkOutput("post-abort read latency", 32'(l0), 32'd2);
        checkOutput("post-abort read data", d0, 32'hDEADBEEF);

        for (int i = 0; i < 400; i++) begin
            reqValid = ($urandom_range(0, 3) != 0);
            reqWrite = 1'($urandom_range(0, 1));
            reqAddr  = pool[$urandom_range(0, 15)];
            reqWdata = $urandom;
            @(negedge clk);
        end
        reqValid = 1'b0;
        waitIdle();
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

CPU-side initiator for the 512x32 synchronous single-port RAM. It accepts one read or write request at a time from the control unit over a valid/ready handshake and drives the RAM's address, write-data and write-enable pins. It waits out the RAM's registered read latency, captures the read word, and returns a one-cycle response pulse. It sits between the MAR/MDR datapath and the RAM, and it is the only block that drives RAM pins.

## Interface
- ADDR_W, 9, RAM address width (512 words)
- DATA_W, 32, word width
- RD_LATENCY, 1, clock edges from RAM address sample to valid RAM data_out; legal range 1..4

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  one-cycle pulse, request complete
- resp_rdata  out  DATA_W  last captured read word
- ram_addr  out  ADDR_W  to RAM addr
- ram_data_in  out  DATA_W  to RAM data_in
- ram_we  out  1  to RAM write_enable
- ram_data_out  in  DATA_W  from RAM data_out

## Operation
- Single clock. Reset is asynchronous and active-low.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge, the request is accepted and req_addr/req_wdata are registered into ram_addr/ram_data_in.
  - If req_write=1: ram_we is set to 1 and the FSM goes to WRITE.
  - If req_write=0: the latency counter is loaded with RD_LATENCY and the FSM goes to READ.
- WRITE: lasts exactly one cycle; ram_we=1 throughout. On the next edge, ram_we is cleared and the FSM goes to RESP.
- READ:
  - If cnt≠0, cnt decrements.
  - If cnt=0, ram_data_out is captured into resp_rdata and the FSM goes to RESP.
  - READ therefore lasts RD_LATENCY+1 cycles.
- RESP: resp_valid=1 for exactly one cycle, then the FSM returns to IDLE.
- req_ready is high only in IDLE. req_valid outside IDLE is ignored, with no queuing and no side effects.
- ram_addr and ram_data_in hold their values from one accept until the next accept. They are never changed mid-request.
- resp_rdata changes only on a read capture. Write responses leave resp_rdata unchanged.
- Address arithmetic: none. req_addr is passed through at ADDR_W bits, so 0x1FF and 0x000 are both ordinary addresses.
- Counter width: 3 bits, sufficient for RD_LATENCY ≤ 4.
- All outputs are registered. There is no combinational path from any input to any output.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, ram_addr=0, ram_data_in=0, ram_we=0, cnt=0.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronously).
  - A write in WRITE state may or may not have landed in RAM; this is the defined behaviour.
  - No response is issued for the aborted request.
- Write: accept at edge E0 → ram_we high during E0–E1 → RAM writes at E1 → resp_valid high during E1–E2 → req_ready high again after E2. Accept-to-response: 1 cycle.
- Read (RD_LATENCY=L): accept at E0 → RAM samples ram_addr at E1 → data valid after E(L) → captured at E(L+1) → resp_valid high during E(L+1)–E(L+2). Accept-to-response: L+1 cycles; L=1 gives 2 cycles.
- Back-to-back throughput:
  - Write: one request per 3 cycles.
  - Read: one request per L+3 cycles.
- Handshake: a request is accepted only on an edge where req_valid=1 and req_ready=1. The request inputs are sampled only on that edge.

## Test plan
- Reset with rst_n=0 mid-cycle → all outputs go to reset values without waiting for a clock edge. Release → req_ready=1.
- Write 0xDEADBEEF to 0x1A5, then read 0x1A5 → ram_we high for exactly 1 cycle; write resp_valid 1 cycle after accept; read resp_valid 2 cycles after accept with resp_rdata=0xDEADBEEF.
- Boundary addresses: write 0x11111111@0x000 and 0x22222222@0x1FF, then read both → values are returned unaliased and ram_addr equals the request address exactly.
- Hold req_valid=1 continuously with alternating new requests → second request accepted only after RESP; requests presented while busy leave ram_addr, ram_we and resp_rdata unchanged.
- RD_LATENCY=3 with the RAM model delayed to match; read 0x0F0 holding 0xCAFEF00D → resp_valid 4 cycles after accept, resp_rdata=0xCAFEF00D.
- Drop rst_n during READ at cnt=1 → no resp_valid, state IDLE, resp_rdata=0. A following read of 0x1A5 completes normally.
